// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative multiply/divide unit owning the HI/LO registers.
//                MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring
//                division, one bit per cycle; MTHI/MTLO write in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MDCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy
);

    localparam int         CNT_W      = $clog2(WIDTH);
    localparam logic [2:0] c_md_mult  = 3'b001;
    localparam logic [2:0] c_md_multu = 3'b010;
    localparam logic [2:0] c_md_div   = 3'b011;
    localparam logic [2:0] c_md_divu  = 3'b100;
    localparam logic [2:0] c_md_mthi  = 3'b101;
    localparam logic [2:0] c_md_mtlo  = 3'b110;
    localparam logic [CNT_W-1:0] c_cnt_last = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]     r_opnd;
    logic                 r_is_div;
    logic                 r_sign_a;
    logic                 r_neg_res;
    logic                 r_div0;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;

    // Operation decode for an instruction arriving while idle
    logic w_idle;
    logic w_is_signed;
    logic w_is_div;
    logic w_launch;
    logic w_a_neg;
    logic w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_is_signed = (MDCode == c_md_mult) || (MDCode == c_md_div);
    assign w_is_div    = (MDCode == c_md_div)  || (MDCode == c_md_divu);
    assign w_launch    = w_idle && start &&
                         ((MDCode == c_md_mult) || (MDCode == c_md_multu) ||
                          (MDCode == c_md_div)  || (MDCode == c_md_divu));
    assign w_a_neg     = w_is_signed && A[WIDTH-1];
    assign w_b_neg     = w_is_signed && B[WIDTH-1];
    assign w_mag_a     = w_a_neg ? (~A + 1'b1) : A;
    assign w_mag_b     = w_b_neg ? (~B + 1'b1) : B;

    // One shift-add multiply step: conditional add into the upper half, then shift right
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;
    assign w_mul_sum  = r_work[0] ? ({1'b0, r_work[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd})
                                  : {1'b0, r_work[2*WIDTH-1:WIDTH]};
    assign w_mul_step = {w_mul_sum, r_work[WIDTH-1:1]};

    // One restoring divide step: shift the next dividend bit in, trial-subtract the divisor
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH+1:0]     w_trial;
    logic                 w_q_bit;
    logic [WIDTH-1:0]     w_rem_new;
    logic [2*WIDTH-1:0]   w_div_step;
    assign w_rem_sh   = {r_work[2*WIDTH-1:WIDTH], r_work[WIDTH-1]};
    assign w_trial    = {1'b0, w_rem_sh} - {2'b00, r_opnd};
    assign w_q_bit    = ~w_trial[WIDTH+1];
    assign w_rem_new  = w_q_bit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_div_step = {w_rem_new, r_work[WIDTH-2:0], w_q_bit};

    // Sign correction applied at the final write; a zero divisor keeps the all-ones quotient
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    assign w_prod_fix = r_neg_res ? (~r_work + 1'b1) : r_work;
    assign w_quot_fix = (r_neg_res && !r_div0) ? (~r_work[WIDTH-1:0] + 1'b1)
                                               : r_work[WIDTH-1:0];
    assign w_rem_fix  = r_sign_a ? (~r_work[2*WIDTH-1:WIDTH] + 1'b1)
                                 : r_work[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_launch) w_state_next = ST_CALC;
            ST_CALC: if (r_cnt == c_cnt_last) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Busy flag registered alongside the state so it equals (state != IDLE)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
        end
    end

    // Operand latch and per-cycle iteration of the working register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_work    <= '0;
            r_opnd    <= '0;
            r_is_div  <= 1'b0;
            r_sign_a  <= 1'b0;
            r_neg_res <= 1'b0;
            r_div0    <= 1'b0;
        end else if (w_launch) begin
            r_cnt     <= '0;
            r_is_div  <= w_is_div;
            r_sign_a  <= w_a_neg;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_div0    <= w_is_div && (B == '0);
            if (w_is_div) begin
                r_work <= {{WIDTH{1'b0}}, w_mag_a};
                r_opnd <= w_mag_b;
            end else begin
                r_work <= {{WIDTH{1'b0}}, w_mag_b};
                r_opnd <= w_mag_a;
            end
        end else if (r_state == ST_CALC) begin
            r_cnt  <= r_cnt + 1'b1;
            r_work <= r_is_div ? w_div_step : w_mul_step;
        end
    end

    // Architectural HI/LO: single-cycle moves when idle, results at the FIX edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == ST_FIX) begin
            if (r_is_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quot_fix;
            end else begin
                r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                r_lo <= w_prod_fix[WIDTH-1:0];
            end
        end else if (w_idle && start) begin
            if (MDCode == c_md_mthi) r_hi <= A;
            if (MDCode == c_md_mtlo) r_lo <= A;
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Directed self-checking bench for mul_div_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDCode (md),
        .A      (a_in),
        .B      (b_in),
        .HI     (hi),
        .LO     (lo),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction for exactly one rising edge; returns 1ns after it
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; md = op; a_in = a; b_in = b;
        @(posedge clk);
        #1;
        start = 1'b0; md = 3'b000; a_in = 32'h0; b_in = 32'h0;
    endtask

    // Count cycles with busy high, bounded so a stuck busy cannot hang the run
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; md = 3'b000; a_in = 32'h0; b_in = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_multu();
        int cyc;
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        #1;
        total++; if (hi !== 32'h0 || lo !== 32'h0) begin
            bad++; $display("FAIL multu_hold: got %h_%h want 0_0", hi, lo); end
        wait_idle(cyc);
        cyc = cyc + 5;
        total++; if (cyc != 33) begin bad++; $display("FAIL multu_busy_cycles: got %0d want 33", cyc); end
        total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    endtask

    task automatic test_mult();
        int cyc;
        issue(3'b001, 32'hFFFF_FFFD, 32'h7);
        wait_idle(cyc);
        total++; if (cyc != 33) begin bad++; $display("FAIL mult_busy_cycles: got %0d want 33", cyc); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    endtask

    task automatic test_div();
        int cyc;
        issue(3'b011, 32'hFFFF_FFF9, 32'h2);
        wait_idle(cyc);
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    endtask

    task automatic test_divu_zero();
        int cyc;
        issue(3'b100, 32'd100, 32'h0);
        wait_idle(cyc);
        total++; if (cyc != 33) begin bad++; $display("FAIL divu0_busy_cycles: got %0d want 33", cyc); end
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
        total++; if (hi !== 32'd100) begin bad++; $display("FAIL divu0_hi: got %h want 00000064", hi); end
    endtask

    task automatic test_div_zero_signed();
        int cyc;
        issue(3'b011, 32'hFFFF_FFF9, 32'h0);
        wait_idle(cyc);
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        total++; if (hi !== 32'hFFFF_FFF9) begin bad++; $display("FAIL div0_hi: got %h want fffffff9", hi); end
    endtask

    task automatic test_div_overflow();
        int cyc;
        issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL divovf_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_mthi();
        logic [31:0] lo_before;
        lo_before = lo;
        issue(3'b101, 32'h1234, 32'h0);
        total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi_hi: got %h want 00001234", hi); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", busy); end
        total++; if (lo !== lo_before) begin bad++; $display("FAIL mthi_lo_kept: got %h want %h", lo, lo_before); end
    endtask

    task automatic test_mtlo_during_mult();
        int cyc;
        logic [31:0] lo_before;
        lo_before = lo;
        issue(3'b010, 32'd3, 32'd5);
        repeat (4) @(posedge clk);
        issue(3'b110, 32'hDEAD_BEEF, 32'h0);
        total++; if (lo !== lo_before) begin bad++; $display("FAIL mtlo_ignored: got %h want %h", lo, lo_before); end
        wait_idle(cyc);
        total++; if (lo !== 32'd15) begin bad++; $display("FAIL mtlo_mult_lo: got %h want 0000000f", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL mtlo_mult_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        // Issued on the first idle edge right after the previous FIX edge
        issue(3'b100, 32'd1000, 32'd7);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
        wait_idle(cyc);
        total++; if (cyc != 33) begin bad++; $display("FAIL b2b_busy_cycles: got %0d want 33", cyc); end
        total++; if (lo !== 32'd142 || hi !== 32'd6) begin
            bad++; $display("FAIL b2b_divu: got hi=%h lo=%h want hi=00000006 lo=0000008e", hi, lo); end
    endtask

    task automatic test_reset_mid_div();
        int cyc;
        issue(3'b011, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (hi !== 32'h0 || lo !== 32'h0) begin
            bad++; $display("FAIL rstmid_hilo: got hi=%h lo=%h want 0 0", hi, lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        issue(3'b010, 32'd6, 32'd7);
        wait_idle(cyc);
        total++; if (cyc != 33) begin bad++; $display("FAIL rstmid_multu_cycles: got %0d want 33", cyc); end
        total++; if (lo !== 32'd42) begin bad++; $display("FAIL rstmid_multu_lo: got %h want 0000002a", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL rstmid_multu_hi: got %h want 00000000", hi); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_divu_zero();
        test_div_zero_signed();
        test_div_overflow();
        test_mthi();
        test_mtlo_during_mult();
        test_back_to_back();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
